cmp_stream_comparator: RTL
==========================

Name: cmp_stream_comparator

Overview:
- Parametrised, registered magnitude comparator: next generation of the 4-bit combinational A/B comparator with Less/Equal/Greater outputs.
- Accepts operand pairs over a valid/ready handshake and returns a one-hot result one cycle later through a single-entry output register with backpressure.
- Keeps saturating per-outcome event counters for link-quality and threshold statistics in the wireless datapath.

Parameters:
- WIDTH, 4, operand width in bits (>=1).
- CNT_W, 8, width of each outcome counter (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- In_valid  input  1  A/B valid this cycle.
- In_ready  output  1  block can accept an operand pair.
- Less  output  1  registered result A<B.
- Equal  output  1  registered result A==B.
- Greater  output  1  registered result A>B.
- Out_valid  output  1  Less/Equal/Greater hold a valid result.
- Out_ready  input  1  consumer accepts the result.
- Cnt_clear  input  1  synchronous clear of all counters.
- Less_cnt  output  CNT_W  number of accepted Less outcomes.
- Equal_cnt  output  CNT_W  number of accepted Equal outcomes.
- Greater_cnt  output  CNT_W  number of accepted Greater outcomes.

Behaviour:
- Reset (rst=1 at a clk edge): Out_valid=0, Less=Equal=Greater=0, all counters=0. In_ready is 0 during reset and 1 in the first cycle after reset.
- In_ready = !Out_valid || Out_ready. This is combinational and gives full throughput: one result per cycle while Out_ready=1.
- Accept = In_valid && In_ready. On accept, the compare result is registered:
  - exactly one of Less/Equal/Greater is 1;
  - Out_valid is 1 the next cycle (latency 1).
- Out_valid=1 && Out_ready=0: result flags hold stable, In_ready=0, and A/B are ignored.
- Out_valid=1 && Out_ready=1 && !In_valid: Out_valid clears the next cycle and the flags go to 0.
- Out_valid=1 && Out_ready=1 && In_valid: the new result replaces the old one back-to-back, and Out_valid stays 1.
- The flags are 0 whenever Out_valid=0.
- Comparison is unsigned over WIDTH bits unless the optional feature selects signed.
- Counters:
  - increment on accept, not on output handshake;
  - each counter saturates at 2^CNT_W-1 and does not wrap.
- Cnt_clear=1 zeroes all counters the next cycle. If Cnt_clear coincides with an accept, the clear wins: counters are 0 and that outcome is not counted. The result path is unaffected.
- Cnt_clear has no effect on Out_valid or the flags.
- rst asserted mid-transfer drops any pending result, with no partial state kept.
- X on A/B while In_valid=0 must not propagate to the outputs.

Optional Feature:
- Macro: CMP_STREAM_SIGNED_EN.
- Defined:
  - adds input port Signed_mode (1 bit), sampled with A/B on accept;
  - Signed_mode=1 compares A and B as two's-complement, Signed_mode=0 compares them as unsigned.
- Undefined:
  - port absent;
  - comparison is always unsigned, and the logic is identical to Signed_mode tied to 0.

Decomposition:
- Shared package cmp_pkg:
  - result-encoding constants CMP_LT=3'b100, CMP_EQ=3'b010, CMP_GT=3'b001 (order Less, Equal, Greater);
  - function cmp_result(a, b, signed_mode) returning the 3-bit one-hot code.
- One sub-module, cmp_sat_counter (CNT_W, inc, clr, count), instantiated three times.
- The top holds the handshake and result register.

Test Plan:
- Reset then single compares, WIDTH=4, Out_ready=1: (8,1), (5,10), (1,2), (15,15) -> one cycle after each accept, Greater, Less, Less, Equal with Out_valid=1. Final counts are Less_cnt=2, Equal_cnt=1, Greater_cnt=1.
- Backpressure: accept (3,3), hold Out_ready=0 for 4 cycles while In_valid=1 with (9,2) -> Equal stable, In_ready=0, no counter change. Then Out_ready=1 -> (9,2) accepted and Greater appears next cycle. Equal_cnt=1, Greater_cnt=1.
- Saturation: CNT_W=2, 5 consecutive accepts of (0,0) -> Equal_cnt reads 1,2,3,3,3.
- Clear collision: Cnt_clear=1 in the same cycle as accept of (1,7) -> all counters 0 next cycle. The Less result is still delivered with Out_valid=1.
- Reset mid-operation: Out_valid=1 with Greater, Out_ready=0, then rst=1 for one cycle -> Out_valid=0, flags 0, counters 0, In_ready=1 the cycle after rst deasserts.
- With CMP_STREAM_SIGNED_EN, WIDTH=4, A=4'b1000, B=4'b0001: Signed_mode=1 -> Less; Signed_mode=0 -> Greater.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared result encoding and compare helper for the stream comparator.
package cmp_pkg;

  // Widest operand cmp_result can handle; callers extend operands to this width.
  localparam int unsigned CMP_MAX_W = 64;

  localparam logic [2:0] CMP_LT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_GT = 3'b001;

  function automatic logic [2:0] cmp_result(input logic [CMP_MAX_W-1:0] a,
                                            input logic [CMP_MAX_W-1:0] b,
                                            input logic                 signed_mode);
    logic [CMP_MAX_W-1:0] ab;
    logic [CMP_MAX_W-1:0] bb;
    ab = a;
    bb = b;
    // Operands arrive sign-extended in signed mode; flipping the MSB maps
    // two's-complement order onto unsigned order.
    if (signed_mode) begin
      ab[CMP_MAX_W-1] = ~a[CMP_MAX_W-1];
      bb[CMP_MAX_W-1] = ~b[CMP_MAX_W-1];
    end
    if (ab < bb) begin
      return CMP_LT;
    end else if (ab == bb) begin
      return CMP_EQ;
    end else begin
      return CMP_GT;
    end
  endfunction

endpackage

// File: rtl/cmp_sat_counter.sv
// Saturating event counter with synchronous clear; clear takes priority over increment.
module cmp_sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cmp_stream_comparator.sv
// Registered magnitude comparator with valid/ready handshake and per-outcome counters.
// Optional signed compare port enabled by macro CMP_STREAM_SIGNED_EN. WIDTH must be <= 64.
module cmp_stream_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef CMP_STREAM_SIGNED_EN
  input  logic             Signed_mode,
`endif
  input  logic             In_valid,
  output logic             In_ready,
  output logic             Less,
  output logic             Equal,
  output logic             Greater,
  output logic             Out_valid,
  input  logic             Out_ready,
  input  logic             Cnt_clear,
  output logic [CNT_W-1:0] Less_cnt,
  output logic [CNT_W-1:0] Equal_cnt,
  output logic [CNT_W-1:0] Greater_cnt
);

  logic signed_mode;
`ifdef CMP_STREAM_SIGNED_EN
  assign signed_mode = Signed_mode;
`else
  assign signed_mode = 1'b0;
`endif

  logic [CMP_MAX_W-1:0] a_ext;
  logic [CMP_MAX_W-1:0] b_ext;
  logic [2:0]           cmp_res;
  logic                 accept;
  logic [2:0]           res_q, res_d;
  logic                 valid_q, valid_d;

  always_comb begin
    a_ext            = {CMP_MAX_W{signed_mode & A[WIDTH-1]}};
    b_ext            = {CMP_MAX_W{signed_mode & B[WIDTH-1]}};
    a_ext[WIDTH-1:0] = A;
    b_ext[WIDTH-1:0] = B;
    cmp_res          = cmp_result(a_ext, b_ext, signed_mode);
  end

  assign In_ready = ~rst & (~valid_q | Out_ready);
  assign accept   = In_valid & In_ready;

  // Flags are cleared on drain so they read 0 whenever Out_valid is 0.
  always_comb begin
    res_d   = res_q;
    valid_d = valid_q;
    if (accept) begin
      res_d   = cmp_res;
      valid_d = 1'b1;
    end else if (Out_ready) begin
      res_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  assign {Less, Equal, Greater} = res_q;
  assign Out_valid              = valid_q;

  cmp_sat_counter #(.CNT_W(CNT_W)) u_less_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept & cmp_res[2]),
    .clr   (Cnt_clear),
    .count (Less_cnt)
  );

  cmp_sat_counter #(.CNT_W(CNT_W)) u_equal_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept & cmp_res[1]),
    .clr   (Cnt_clear),
    .count (Equal_cnt)
  );

  cmp_sat_counter #(.CNT_W(CNT_W)) u_greater_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept & cmp_res[0]),
    .clr   (Cnt_clear),
    .count (Greater_cnt)
  );

endmodule
